expr_eval_ctrl: RTL

- Byte-stream controller that validates and evaluates single-digit arithmetic expressions, e.g. "3+4*2=".
- ASCII characters arrive over a valid/ready handshake and are checked against the digit/operator alternation grammar.
- A W-bit accumulator is updated strictly left to right, with no operator precedence.
- On '=', the result or an error is presented on a held output with an acknowledge handshake. The block sits between the character source and the result consumer.

---
 rtl/expr_eval_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/expr_eval_ctrl.sv
// Left-to-right single-digit expression evaluator: validates a digit/operator
// byte stream and presents the W-bit result (or a syntax error) on '='.
module expr_eval_ctrl #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [7:0]   in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         syn_ok,
    output logic [W-1:0] res,
    output logic         res_err,
    output logic         res_valid,
    input  logic         res_ack
);

    typedef enum logic [1:0] {EXP_NUM, EXP_OP, ERR, DONE} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

    state_t         r_state, w_state_nxt;
    op_t            r_op, w_op_nxt;
    logic [W-1:0]   r_acc, w_acc_nxt;
    logic           r_first, w_first_nxt;
    logic [W-1:0]   r_res, w_res_nxt;
    logic           r_res_err, w_res_err_nxt;

    logic           w_accept;
    logic           w_is_digit, w_is_op, w_is_eq;
    logic [7:0]     w_dig_byte;
    logic [W-1:0]   w_d;
    logic [W-1:0]   w_alu;
    op_t            w_in_op;

    assign in_ready   = (r_state != DONE);
    assign syn_ok     = (r_state == EXP_OP);
    assign res_valid  = (r_state == DONE);
    assign res        = r_res;
    assign res_err    = r_res_err;

    assign w_accept   = in_valid && in_ready;
    assign w_is_digit = (in >= 8'h30) && (in <= 8'h39);
    assign w_is_op    = (in == 8'h2B) || (in == 8'h2D) || (in == 8'h2A);
    assign w_is_eq    = (in == 8'h3D);
    assign w_dig_byte = in - 8'h30;
    assign w_d        = {{(W-4){1'b0}}, w_dig_byte[3:0]};

    always_comb begin
        w_in_op = OP_ADD;
        if (in == 8'h2D)
            w_in_op = OP_SUB;
        else if (in == 8'h2A)
            w_in_op = OP_MUL;
    end

    always_comb begin
        w_alu = r_acc + w_d;
        case (r_op)
            OP_SUB:  w_alu = r_acc - w_d;
            OP_MUL:  w_alu = r_acc * w_d;
            default: w_alu = r_acc + w_d;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_op_nxt      = r_op;
        w_acc_nxt     = r_acc;
        w_first_nxt   = r_first;
        w_res_nxt     = r_res;
        w_res_err_nxt = r_res_err;
        case (r_state)
            EXP_NUM: if (w_accept) begin
                if (w_is_digit) begin
                    w_acc_nxt   = r_first ? w_d : w_alu;
                    w_first_nxt = 1'b0;
                    w_state_nxt = EXP_OP;
                end else if (w_is_eq) begin
                    w_res_nxt     = '0;
                    w_res_err_nxt = 1'b1;
                    w_state_nxt   = DONE;
                end else begin
                    w_state_nxt = ERR;
                end
            end
            EXP_OP: if (w_accept) begin
                if (w_is_op) begin
                    w_op_nxt    = w_in_op;
                    w_state_nxt = EXP_NUM;
                end else if (w_is_eq) begin
                    w_res_nxt     = r_acc;
                    w_res_err_nxt = 1'b0;
                    w_state_nxt   = DONE;
                end else begin
                    w_state_nxt = ERR;
                end
            end
            ERR: if (w_accept && w_is_eq) begin
                w_res_nxt     = '0;
                w_res_err_nxt = 1'b1;
                w_state_nxt   = DONE;
            end
            DONE: if (res_ack) begin
                w_acc_nxt   = '0;
                w_first_nxt = 1'b1;
                w_op_nxt    = OP_ADD;
                w_state_nxt = EXP_NUM;
            end
            default: w_state_nxt = EXP_NUM;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= EXP_NUM;
            r_op      <= OP_ADD;
            r_acc     <= '0;
            r_first   <= 1'b1;
            r_res     <= '0;
            r_res_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_op      <= w_op_nxt;
            r_acc     <= w_acc_nxt;
            r_first   <= w_first_nxt;
            r_res     <= w_res_nxt;
            r_res_err <= w_res_err_nxt;
        end
    end

endmodule
